// File: rtl/huffman_sort_ctrl.sv
// huffman_sort_ctrl
// Sequencing controller around an external combinational 8-entry sort IP.
// Loads eight symbol weights, then runs seven sort/merge steps to build a
// Huffman tree. Finally it emits one code length and code word per symbol.
//
// Ports
//   clk            system clock, all state on the rising edge
//   rst            asynchronous active-high reset
//   in_valid       weight-load strobe (honoured only while idle/loading)
//   in_weight      weight of the next symbol, symbols arrive in order 0..7
//   sort_char_o    node IDs presented to the sort IP, slot 0 at [31:28]
//   sort_weight_o  weights presented to the sort IP, slot 0 at [39:35]
//   sort_char_i    node IDs returned by the sort IP, descending weight
//   out_valid      code output strobe, eight consecutive cycles per job
//   out_len        code length of the current symbol (0 when idle)
//   out_code       code bits, bit 0 is the leaf-most bit (0 when idle)
//   busy           high while a job is in flight
module huffman_sort_ctrl #(
  parameter int IP_WIDTH = 8,
  parameter int WEIGHT_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WEIGHT_W-1:0]          in_weight,
  output logic [4*IP_WIDTH-1:0]        sort_char_o,
  output logic [WEIGHT_W*IP_WIDTH-1:0] sort_weight_o,
  input  logic [4*IP_WIDTH-1:0]        sort_char_i,
  output logic                         out_valid,
  output logic [2:0]                   out_len,
  output logic [6:0]                   out_code,
  output logic                         busy
);

  localparam logic [3:0]          EMPTY_ID = 4'd15;
  localparam logic [WEIGHT_W-1:0] WT_MAX   = {WEIGHT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SORT  = 3'd2,
    S_MERGE = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                  state_r;
  logic [WEIGHT_W-1:0]     wt_r   [0:14];
  logic [3:0]              slot_r [0:IP_WIDTH-1];
  logic [3:0]              root_r [0:IP_WIDTH-1];
  logic [2:0]              len_r  [0:IP_WIDTH-1];
  logic [6:0]              code_r [0:IP_WIDTH-1];
  logic [2:0]              step_r;
  logic [2:0]              cnt_r;
  logic [4*IP_WIDTH-1:0]   sorted_r;

  logic [WEIGHT_W-1:0]     wt_all_s  [0:15];
  logic [3:0]              x_s;
  logic [3:0]              y_s;
  logic [3:0]              n_s;
  logic [WEIGHT_W:0]       sum_s;
  logic [WEIGHT_W-1:0]     merged_wt_s;
  logic [3:0]              nslot_s   [0:IP_WIDTH-1];
  logic [3:0]              nroot_s   [0:IP_WIDTH-1];
  logic [2:0]              nlen_s    [0:IP_WIDTH-1];
  logic [6:0]              ncode_s   [0:IP_WIDTH-1];
  logic [4*IP_WIDTH-1:0]        merge_char_s;
  logic [WEIGHT_W*IP_WIDTH-1:0] merge_weight_s;
  logic [4*IP_WIDTH-1:0]        load_char_s;
  logic [WEIGHT_W*IP_WIDTH-1:0] load_weight_s;
  logic                    sort_ok_s;

  // XOR of all node IDs in a slot vector; a reordering never changes it.
  function automatic logic [3:0] id_xor(input logic [4*IP_WIDTH-1:0] v);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < IP_WIDTH; i++) begin
      acc = acc ^ v[4*i +: 4];
    end
    return acc;
  endfunction

  // Weight lookup by node ID; the empty marker always weighs the maximum.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      wt_all_s[i] = wt_r[i];
    end
    wt_all_s[15] = WT_MAX;
  end

  // Merge datapath: combine the two lightest roots into node 8+step.
  always_comb begin
    x_s   = sorted_r[3:0];
    y_s   = sorted_r[7:4];
    n_s   = {1'b1, step_r};
    sum_s = {1'b0, wt_all_s[x_s]} + {1'b0, wt_all_s[y_s]};
    if (sum_s[WEIGHT_W]) begin
      merged_wt_s = WT_MAX;
    end else begin
      merged_wt_s = sum_s[WEIGHT_W-1:0];
    end
    merge_char_s   = {(4*IP_WIDTH){1'b0}};
    merge_weight_s = {(WEIGHT_W*IP_WIDTH){1'b0}};
    for (int i = 0; i < IP_WIDTH; i++) begin
      if (slot_r[i] == x_s) begin
        nslot_s[i] = n_s;
      end else if (slot_r[i] == y_s) begin
        nslot_s[i] = EMPTY_ID;
      end else begin
        nslot_s[i] = slot_r[i];
      end
      // X side of the merge contributes a 1 bit, Y side a 0 bit.
      if (root_r[i] == x_s) begin
        ncode_s[i] = code_r[i] | (7'd1 << len_r[i]);
        nlen_s[i]  = len_r[i] + 3'd1;
        nroot_s[i] = n_s;
      end else if (root_r[i] == y_s) begin
        ncode_s[i] = code_r[i] & ~(7'd1 << len_r[i]);
        nlen_s[i]  = len_r[i] + 3'd1;
        nroot_s[i] = n_s;
      end else begin
        ncode_s[i] = code_r[i];
        nlen_s[i]  = len_r[i];
        nroot_s[i] = root_r[i];
      end
      merge_char_s[4*(IP_WIDTH-1-i) +: 4] = nslot_s[i];
      // The new node's weight is not in wt_r yet, so bypass it here.
      if (nslot_s[i] == n_s) begin
        merge_weight_s[WEIGHT_W*(IP_WIDTH-1-i) +: WEIGHT_W] = merged_wt_s;
      end else begin
        merge_weight_s[WEIGHT_W*(IP_WIDTH-1-i) +: WEIGHT_W] = wt_all_s[nslot_s[i]];
      end
    end
  end

  // First sort request: leaves in symbol order, last weight still on the input.
  always_comb begin
    load_char_s   = {(4*IP_WIDTH){1'b0}};
    load_weight_s = {(WEIGHT_W*IP_WIDTH){1'b0}};
    for (int i = 0; i < IP_WIDTH; i++) begin
      load_char_s[4*(IP_WIDTH-1-i) +: 4] = 4'(i);
      if (i == IP_WIDTH - 1) begin
        load_weight_s[WEIGHT_W*(IP_WIDTH-1-i) +: WEIGHT_W] = in_weight;
      end else begin
        load_weight_s[WEIGHT_W*(IP_WIDTH-1-i) +: WEIGHT_W] = wt_r[i];
      end
    end
  end

  // A sort result that is not a reordering of the request is sorted again.
  always_comb begin
    sort_ok_s = (id_xor(sorted_r) == id_xor(sort_char_o));
  end

  // Controller FSM with all tables and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      step_r        <= 3'd0;
      cnt_r         <= 3'd0;
      sorted_r      <= {(4*IP_WIDTH){1'b0}};
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      out_len       <= 3'd0;
      out_code      <= 7'd0;
      sort_char_o   <= {(4*IP_WIDTH){1'b0}};
      sort_weight_o <= {(WEIGHT_W*IP_WIDTH){1'b0}};
      for (int i = 0; i < 15; i++) begin
        wt_r[i] <= {WEIGHT_W{1'b0}};
      end
      for (int i = 0; i < IP_WIDTH; i++) begin
        slot_r[i] <= 4'd0;
        root_r[i] <= 4'd0;
        len_r[i]  <= 3'd0;
        code_r[i] <= 7'd0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            wt_r[0] <= in_weight;
            cnt_r   <= 3'd1;
            busy    <= 1'b1;
            state_r <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            wt_r[cnt_r] <= in_weight;
            if (cnt_r == 3'd7) begin
              for (int i = 0; i < IP_WIDTH; i++) begin
                slot_r[i] <= 4'(i);
                root_r[i] <= 4'(i);
                len_r[i]  <= 3'd0;
                code_r[i] <= 7'd0;
              end
              step_r        <= 3'd0;
              sort_char_o   <= load_char_s;
              sort_weight_o <= load_weight_s;
              state_r       <= S_SORT;
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
        S_SORT: begin
          sorted_r <= sort_char_i;
          state_r  <= S_MERGE;
        end
        S_MERGE: begin
          if (!sort_ok_s) begin
            state_r <= S_SORT;
          end else begin
            wt_r[n_s] <= merged_wt_s;
            for (int i = 0; i < IP_WIDTH; i++) begin
              slot_r[i] <= nslot_s[i];
              root_r[i] <= nroot_s[i];
              len_r[i]  <= nlen_s[i];
              code_r[i] <= ncode_s[i];
            end
            sort_char_o   <= merge_char_s;
            sort_weight_o <= merge_weight_s;
            if (step_r == 3'd6) begin
              // Symbol 0 goes out straight from the final merge result.
              cnt_r     <= 3'd0;
              out_valid <= 1'b1;
              out_len   <= nlen_s[0];
              out_code  <= ncode_s[0];
              state_r   <= S_OUT;
            end else begin
              step_r  <= step_r + 3'd1;
              state_r <= S_SORT;
            end
          end
        end
        S_OUT: begin
          if (cnt_r == 3'd7) begin
            cnt_r     <= 3'd0;
            out_valid <= 1'b0;
            out_len   <= 3'd0;
            out_code  <= 7'd0;
            busy      <= 1'b0;
            state_r   <= S_IDLE;
          end else begin
            cnt_r    <= cnt_r + 3'd1;
            out_len  <= len_r[cnt_r + 3'd1];
            out_code <= code_r[cnt_r + 3'd1];
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_sort_ctrl.sv
// Testbench for huffman_sort_ctrl: behavioural sort IP, Huffman reference
// model, per-cycle output comparison and directed job scenarios.
module tb_huffman_sort_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_weight = 5'd0;
  logic [31:0] sort_char_o;
  logic [39:0] sort_weight_o;
  logic [31:0] sort_char_i;
  logic        out_valid;
  logic [2:0]  out_len;
  logic [6:0]  out_code;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int job_first = -1;
  int job_last  = -1;
  int wts      [0:7];
  int exp_len  [0:7];
  int exp_code [0:7];
  int mx       [0:6];
  int my       [0:6];
  int pin_b_len [0:7] = '{5, 4, 3, 2, 1, 7, 7, 6};
  int pin_c_x   [0:6] = '{0, 2, 4, 6, 8, 10, 12};
  int pin_c_y   [0:6] = '{1, 3, 5, 7, 9, 11, 13};

  huffman_sort_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_weight     (in_weight),
    .sort_char_o   (sort_char_o),
    .sort_weight_o (sort_weight_o),
    .sort_char_i   (sort_char_i),
    .out_valid     (out_valid),
    .out_len       (out_len),
    .out_code      (out_code),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sort IP: descending by weight, ties broken by larger ID first.
  function automatic logic [31:0] ip_sort(input logic [31:0] c, input logic [39:0] w);
    logic [8:0]  key [0:7];
    logic [8:0]  tmp;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) key[i] = {w[39-5*i -: 5], c[31-4*i -: 4]};
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (key[j] < key[j+1]) begin
          tmp = key[j]; key[j] = key[j+1]; key[j+1] = tmp;
        end
    r = 32'd0;
    for (int i = 0; i < 8; i++) r[31-4*i -: 4] = key[i][3:0];
    return r;
  endfunction

  assign sort_char_i = ip_sort(sort_char_o, sort_weight_o);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d,
                       input int e, input int f, input int g, input int h);
    wts[0] = a; wts[1] = b; wts[2] = c; wts[3] = d;
    wts[4] = e; wts[5] = f; wts[6] = g; wts[7] = h;
  endtask

  // Huffman reference: repeatedly merge the two lightest live nodes
  // (lower ID counts as lighter on ties), then read codes by walking
  // from each leaf up to the root.
  task automatic run_model();
    int nw [0:15];
    bit live [0:15];
    int par [0:15];
    bit isx [0:15];
    int x, y, n, node, d, code;
    for (int i = 0; i < 16; i++) begin
      nw[i] = 0; live[i] = 1'b0; par[i] = 14; isx[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      nw[i] = wts[i]; live[i] = 1'b1;
    end
    for (int k = 0; k < 7; k++) begin
      x = -1; y = -1;
      for (int id = 0; id < 15; id++)
        if (live[id] && (x < 0 || nw[id] < nw[x])) x = id;
      for (int id = 0; id < 15; id++)
        if (live[id] && id != x && (y < 0 || nw[id] < nw[y])) y = id;
      n = 8 + k;
      nw[n] = (nw[x] + nw[y] > 31) ? 31 : nw[x] + nw[y];
      live[x] = 1'b0; live[y] = 1'b0; live[n] = 1'b1;
      par[x] = n; isx[x] = 1'b1;
      par[y] = n; isx[y] = 1'b0;
      mx[k] = x; my[k] = y;
    end
    for (int i = 0; i < 8; i++) begin
      node = i; d = 0; code = 0;
      while (node != 14 && d < 8) begin
        if (isx[node]) code = code | (1 << d);
        d++;
        node = par[node];
      end
      exp_len[i] = d; exp_code[i] = code;
    end
  endtask

  // Presents the eight weights; gapmode 1 inserts i%4 idle cycles after weight i.
  task automatic drive_job(input int gapmode);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_weight = 5'(wts[i]);
      if (i == 0) begin job_first = cyc; job_last = -1; end
      if (i == 7) job_last = cyc;
      if (gapmode != 0 && i < 7)
        for (int g = 0; g < (i % 4); g++) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
        end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = job_last;
    while (cyc < t + 24) begin
      @(posedge clk); #1;
    end
  endtask

  // Stray in_valid pulses while the job is past loading.
  task automatic drive_noise();
    int t, rel;
    t = job_last;
    while (cyc < t + 23) begin
      rel = cyc - t;
      in_valid  = (rel == 1 || rel == 2 || rel == 7 || rel == 14 || rel == 15 || rel == 22);
      in_weight = 5'd9;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  int c_rel, c_ev, c_el, c_ec, c_eb;

  // Per-cycle comparison against the timeline implied by the current job.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_len", out_len, 0);
      chk("rst_out_code", out_code, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sort_char", sort_char_o, 0);
      chk("rst_sort_weight", sort_weight_o, 0);
    end else begin
      c_ev = 0; c_el = 0; c_ec = 0; c_eb = 0;
      if (job_first >= 0 && cyc > job_first && (job_last < 0 || cyc <= job_last + 22)) c_eb = 1;
      if (job_last >= 0) begin
        c_rel = cyc - job_last;
        if (c_rel >= 15 && c_rel <= 22) begin
          c_ev = 1; c_el = exp_len[c_rel-15]; c_ec = exp_code[c_rel-15];
        end
        if (c_rel >= 1 && c_rel <= 13 && (c_rel % 2) == 1) begin
          chk("merge_x", sort_char_i[3:0], mx[(c_rel-1)/2]);
          chk("merge_y", sort_char_i[7:4], my[(c_rel-1)/2]);
        end
      end
      chk("out_valid", out_valid, c_ev);
      chk("out_len", out_len, c_el);
      chk("out_code", out_code, c_ec);
      chk("busy", busy, c_eb);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // All weights 1: balanced tree of depth 3.
    set_w(1, 1, 1, 1, 1, 1, 1, 1);
    run_model();
    for (int i = 0; i < 8; i++) chk("model_a_len", exp_len[i], 3);
    chk("model_a_code0", exp_code[0], 7);
    chk("model_a_code7", exp_code[7], 0);
    drive_job(0);
    wait_done();

    // Powers of two with three zero weights.
    set_w(1, 2, 4, 8, 16, 0, 0, 0);
    run_model();
    for (int i = 0; i < 8; i++) chk("model_b_len", exp_len[i], pin_b_len[i]);
    chk("model_b_code4", exp_code[4], 0);
    chk("model_b_code3", exp_code[3], 2);
    drive_job(0);
    wait_done();

    // Saturating weights: merge order driven purely by IDs.
    set_w(31, 31, 31, 31, 31, 31, 31, 31);
    run_model();
    for (int k = 0; k < 7; k++) begin
      chk("model_c_x", mx[k], pin_c_x[k]);
      chk("model_c_y", my[k], pin_c_y[k]);
    end
    for (int i = 0; i < 8; i++) chk("model_c_len", exp_len[i], 3);
    drive_job(0);
    wait_done();

    // Same as job B but with load gaps of 0..3 cycles.
    set_w(1, 2, 4, 8, 16, 0, 0, 0);
    run_model();
    drive_job(1);
    wait_done();

    // Mixed weights.
    set_w(3, 1, 4, 1, 5, 9, 2, 6);
    run_model();
    drive_job(0);
    wait_done();

    // Reset during merge step 3, then a fresh all-1 job.
    set_w(1, 1, 1, 1, 1, 1, 1, 1);
    run_model();
    drive_job(0);
    t = job_last;
    while (cyc < t + 8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    job_first = -1;
    job_last  = -1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_model();
    drive_job(0);
    wait_done();

    // Stray in_valid pulses during SORT/MERGE/OUT.
    set_w(1, 2, 4, 8, 16, 0, 0, 0);
    run_model();
    drive_job(0);
    drive_noise();
    wait_done();

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/huffman_sort_ctrl.md
# huffman_sort_ctrl

Sequencing controller for the combinational 8-entry sort IP. Loads eight 5-bit symbol weights, then drives the sort IP for seven iterative merge steps to build a Huffman tree. Emits one code length and one code word per symbol. Sits between the weight source and the sort IP; the sort IP is instantiated outside and connected through the `sort_*` ports.

## Interface
Parameters:
- IP_WIDTH, 8: entries per sort; fixed at 8 for this block.
- WEIGHT_W, 5: weight width per entry.

Ports:
- clk  in  1  system clock; single clock domain; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  weight-load strobe.
- in_weight  in  5  weight of the next symbol.
- sort_char_o  out  32  to sort IP `IN_character`; 8 × 4-bit node IDs, slot 0 at [31:28].
- sort_weight_o  out  40  to sort IP `IN_weight`; 8 × 5-bit weights, slot 0 at [39:35].
- sort_char_i  in  32  from sort IP `OUT_character`.
- out_valid  out  1  code output strobe.
- out_len  out  3  code length of the current symbol.
- out_code  out  7  code bits; bit 0 is the leaf-most bit.
- busy  out  1  high from the first accepted weight until the cycle after the last out_valid.

## Operation
- Sort IP contract:
  - Descending weight.
  - Equal weights: larger ID placed earlier.
  - Output position 0 is [31:28]; the two smallest entries are at [3:0] and [7:4].
- Node IDs:
  - 0–7: leaves, symbol order.
  - 8–14: merged nodes; node 8+k is created at step k.
  - 15: empty marker, weight fixed at 31.
  - The empty marker always sorts ahead of valid nodes by the tie rule.
- State:
  - `wt[0..14]`: weights, 5 bits each.
  - `slot[0..7]`: root IDs.
  - Per leaf: `root`, `len`, `code`.
  - `step`: 3 bits.
  - `cnt`: 3 bits.
- FSM IDLE:
  - On in_valid: store the weight into `wt[0]`, set `cnt=1`, go to LOAD.
  - Otherwise stay.
- FSM LOAD:
  - Each in_valid cycle stores into `wt[cnt]` and increments `cnt`.
  - Gaps (in_valid low) hold `cnt`.
  - After the 8th weight, go to SORT.
  - Initialise `slot[i]=i`, `root[i]=i`, `len=0`, `code=0`, `step=0`.
- FSM SORT:
  - `sort_*_o` are registered from `slot`/`wt`.
  - Capture `sort_char_i` into `sorted_r` at the end of the cycle.
  - Go to MERGE.
- FSM MERGE:
  - X = `sorted_r[3:0]` (smallest), Y = `sorted_r[7:4]`, N = 8+`step`.
  - Weight update: `wt[N] = min(wt[X]+wt[Y], 31)`. The sum is computed 6 bits wide and saturated.
  - Slot update: the slot holding X becomes N; the slot holding Y becomes 15.
  - Every leaf with root==X: `code[len]=1`, `len++`, `root=N`.
  - Every leaf with root==Y: `code[len]=0`, `len++`, `root=N`.
  - `step==6`: go to OUT. Otherwise `step++` and go to SORT.
- FSM OUT:
  - 8 cycles; `out_valid=1`.
  - `out_len`/`out_code` for leaf `cnt`, symbols 0..7 in order.
  - Then go to IDLE.
- in_valid outside IDLE/LOAD is ignored. The pattern must not drive it.
- Precondition: weights sum ≤31. Violations are defined only by the saturation rule. No X may appear on outputs.

## Timing
- Reset values:
  - out_valid=0, out_len=0, out_code=0, busy=0, sort_char_o=0, sort_weight_o=0.
  - FSM=IDLE, all tables 0.
- Reset mid-operation returns to IDLE immediately. The current job is discarded.
- Last weight accepted at cycle t:
  - SORT k at t+1+2k; MERGE k at t+2+2k, for k=0..6.
  - out_valid high at t+15 … t+22, inclusive.
  - busy low from t+23.
  - A new in_valid is accepted at t+23 or later.
- The sort IP is purely combinational. The only constraint is one-cycle settle from `sort_*_o` to capture.
- out_len/out_code hold 0 when out_valid=0.

## Test plan
- All weights 1 → lengths 3,3,3,3,3,3,3,3; char0 code 3'b111, char7 code 3'b000; out_valid at t+15..t+22.
- Weights 1,2,4,8,16,0,0,0 → lengths 5,4,3,2,1,7,7,6; char4 code 0, char3 code 7'b0000010.
- All weights 31 (saturation) → all lengths 3, merge order (0,1),(2,3),(4,5),(6,7),(8,9),(10,11),(12,13); no X.
- Load with in_valid gaps of 0–3 cycles between weights → identical results and latency counted from the last weight.
- rst pulsed during MERGE step 3, then a fresh load of all-1 weights → outputs low through reset; second job correct with nominal latency.
- in_valid pulsed during SORT/MERGE/OUT → ignored; results and timing unchanged.
